// File: rtl/instruction_sequencer_if.sv
// Host register / core control bundle for instruction_sequencer.
// slave = the sequencer, master = whoever drives the SPI regs and done.
interface instruction_sequencer_if;
  logic [7:0] instruction;
  logic [7:0] mode;
  logic [7:0] trigger_channel_mask;
  logic       readout_done;
  logic       acq_en;
  logic [7:0] trig_mask;
  logic       cal_pulse;
  logic       readout_req;
  logic       soft_rst;
  logic       busy;
  logic       cmd_err;
  logic [2:0] state_dbg;

  modport slave (
    input  instruction, mode, trigger_channel_mask,
    input  readout_done,
    output acq_en, trig_mask, cal_pulse, readout_req,
    output soft_rst, busy, cmd_err, state_dbg
  );

  modport master (
    output instruction, mode, trigger_channel_mask,
    output readout_done,
    input  acq_en, trig_mask, cal_pulse, readout_req,
    input  soft_rst, busy, cmd_err, state_dbg
  );
endinterface

// File: rtl/instruction_sequencer.sv
// Resynchronises the SPI command registers into iclk and runs the
// acquisition / calibration / readout / soft-reset sequences.
module instruction_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int CAL_CYCLES  = 16,
  parameter int RST_CYCLES  = 4,
  parameter int RO_TIMEOUT  = 1024
) (
  input logic                    iclk,
  input logic                    rst,
  instruction_sequencer_if.slave bus
);
  localparam int MAX_A = (CAL_CYCLES > RST_CYCLES) ?
                         CAL_CYCLES : RST_CYCLES;
  localparam int MAXP  = (MAX_A > RO_TIMEOUT) ?
                         MAX_A : RO_TIMEOUT;
  localparam int CW    = $clog2(MAXP) + 1;

  localparam logic [7:0] OP_START = 8'h01;
  localparam logic [7:0] OP_STOP  = 8'h02;
  localparam logic [7:0] OP_SRST  = 8'h03;
  localparam logic [7:0] OP_CAL   = 8'h04;
  localparam logic [7:0] OP_RO    = 8'h05;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ACQ  = 3'd1,
    S_CAL  = 3'd2,
    S_RO   = 3'd3,
    S_SRST = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0][7:0] r_ins_s;
  logic [SYNC_STAGES-1:0][7:0] r_mask_s;
  logic [SYNC_STAGES-1:0]      r_mode_s;
  logic [7:0] r_ins_p;
  logic [7:0] r_mask_p;
  logic       r_mode_p;
  logic [7:0] r_mask_q;
  logic       r_mode_q;

  logic       r_armed;
  logic       r_cmd_vld;
  logic [7:0] r_cmd;
  logic [7:0] r_cmd_mask;
  logic       r_cmd_cont;

  state_t     r_state;
  logic [CW-1:0] r_cnt;
  logic       r_ro_cont;
  logic       r_acq;
  logic [7:0] r_mask;
  logic       r_cal;
  logic       r_req;
  logic       r_srst;
  logic       r_err;

  logic [7:0] w_ins;
  logic       w_ins_qv;
  logic [7:0] w_mask_q;
  logic       w_mode_q;
  logic       w_open;
  logic       w_acc;

  // A word only counts once it has looked the same on two cycles
  assign w_ins    = r_ins_s[SYNC_STAGES-1];
  assign w_ins_qv = (w_ins == r_ins_p);
  assign w_mask_q = (r_mask_s[SYNC_STAGES-1] == r_mask_p) ?
                    r_mask_p : r_mask_q;
  assign w_mode_q = (r_mode_s[SYNC_STAGES-1] == r_mode_p) ?
                    r_mode_p : r_mode_q;
  assign w_open   = (r_state == S_IDLE) || (r_state == S_ACQ);
  assign w_acc    = w_ins_qv && (w_ins != 8'h00) && r_armed &&
                    (w_open || (w_ins == OP_SRST));

  always_ff @(posedge iclk) begin
    if (rst) begin
      r_ins_s    <= '0;
      r_mask_s   <= '0;
      r_mode_s   <= '0;
      r_ins_p    <= '0;
      r_mask_p   <= '0;
      r_mode_p   <= 1'b0;
      r_mask_q   <= '0;
      r_mode_q   <= 1'b0;
      r_armed    <= 1'b1;
      r_cmd_vld  <= 1'b0;
      r_cmd      <= '0;
      r_cmd_mask <= '0;
      r_cmd_cont <= 1'b0;
    end else begin
      r_ins_s  <= {r_ins_s[SYNC_STAGES-2:0],
                   bus.instruction};
      r_mask_s <= {r_mask_s[SYNC_STAGES-2:0],
                   bus.trigger_channel_mask};
      r_mode_s <= {r_mode_s[SYNC_STAGES-2:0],
                   bus.mode[0]};
      r_ins_p   <= w_ins;
      r_mask_p  <= r_mask_s[SYNC_STAGES-1];
      r_mode_p  <= r_mode_s[SYNC_STAGES-1];
      r_mask_q  <= w_mask_q;
      r_mode_q  <= w_mode_q;
      r_cmd_vld <= w_acc;
      if (w_acc) begin
        r_cmd      <= w_ins;
        r_cmd_mask <= w_mask_q;
        r_cmd_cont <= w_mode_q;
        r_armed    <= 1'b0;
      end else if (w_ins_qv && (w_ins == 8'h00)) begin
        r_armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge iclk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_ro_cont <= 1'b0;
      r_acq     <= 1'b0;
      r_mask    <= '0;
      r_cal     <= 1'b0;
      r_req     <= 1'b0;
      r_srst    <= 1'b0;
      r_err     <= 1'b0;
    end else if (r_cmd_vld && (r_cmd == OP_SRST)) begin
      r_state <= S_SRST;
      r_cnt   <= '0;
      r_acq   <= 1'b0;
      r_mask  <= '0;
      r_cal   <= 1'b0;
      r_req   <= 1'b0;
      r_srst  <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (r_cmd_vld) begin
          r_err <= 1'b0;
          unique case (1'b1)
            (r_cmd == OP_START): begin
              r_state <= S_ACQ;
              r_acq   <= 1'b1;
              r_mask  <= r_cmd_mask;
            end
            (r_cmd == OP_STOP): ;
            (r_cmd == OP_CAL): begin
              r_state <= S_CAL;
              r_cal   <= 1'b1;
              r_cnt   <= '0;
            end
            (r_cmd == OP_RO): begin
              r_state   <= S_RO;
              r_req     <= 1'b1;
              r_cnt     <= '0;
              r_ro_cont <= r_cmd_cont;
            end
            default: r_err <= 1'b1;
          endcase
        end
        S_ACQ: if (r_cmd_vld) begin
          r_err <= 1'b0;
          unique case (1'b1)
            (r_cmd == OP_STOP): begin
              r_state <= S_IDLE;
              r_acq   <= 1'b0;
              r_mask  <= '0;
            end
            (r_cmd == OP_RO): begin
              r_state   <= S_RO;
              r_acq     <= 1'b0;
              r_req     <= 1'b1;
              r_cnt     <= '0;
              r_ro_cont <= r_cmd_cont;
            end
            default: r_err <= 1'b1;
          endcase
        end
        S_CAL: begin
          if (r_cnt == CW'(CAL_CYCLES - 1)) begin
            r_state <= S_IDLE;
            r_cal   <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RO: begin
          // done has priority over a coincident timeout
          if (bus.readout_done) begin
            r_req <= 1'b0;
            r_cnt <= '0;
            if (r_ro_cont) begin
              r_state <= S_ACQ;
              r_acq   <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_mask  <= '0;
            end
          end else if (r_cnt == CW'(RO_TIMEOUT - 1)) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_err   <= 1'b1;
            r_mask  <= '0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_SRST: begin
          if (r_cnt == CW'(RST_CYCLES - 1)) begin
            r_state <= S_IDLE;
            r_srst  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.acq_en      = r_acq;
  assign bus.trig_mask   = r_mask;
  assign bus.cal_pulse   = r_cal;
  assign bus.readout_req = r_req;
  assign bus.soft_rst    = r_srst;
  assign bus.cmd_err     = r_err;
  assign bus.state_dbg   = r_state;
  assign bus.busy        = (r_state != S_IDLE);
endmodule
